// File: rtl/mem_arbiter4_pkg.sv
// Shared definitions for the 4-way memory arbiter.
//   arb_state_e     : FSM state encoding (IDLE / BUSY)
//   TIMEOUT_DEFAULT : default abort limit in BUSY cycles
//   CNT_W           : width of the BUSY wait counter
//   onehot4()       : 2-bit index to 4-bit one-hot decode
package mem_arbiter4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = 7;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mem_arbiter4_rr_pick4.sv
// Rotating-priority search over four requesters.
//   req   : request vector, bit i = requester i
//   ptr   : index that has highest priority this round
//   valid : at least one request present
//   idx   : first requester found searching ptr, ptr+1, ... modulo 4
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the
  // last assignment and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter4.sv
// Four-requester round-robin arbiter for a shared memory resource.
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   req   : per-requester level request
//   done  : completion strobe from the current owner (BUSY only)
//   grant : one-hot owner, zero when idle
//   sel   : binary owner index, holds its value while idle
//   busy  : a grant is held
//   err   : one-cycle pulse when a grant is aborted on timeout
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; a non-zero req is arbitrated and granted next edge
// BUSY  | owner holds the resource until done or the wait limit
//
// All outputs come straight from flops.
module mem_arbiter4
  import mem_arbiter4_pkg::*;
#(
  // The wait counter is CNT_W (7) bits, so values above 128 cannot be reached.
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic             err_q,   err_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic       pick_valid;
  logic [1:0] pick_idx;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          grant_d = onehot4(pick_idx);
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // done takes priority over the timeout on the same cycle.
        if (done || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = sel_q + 2'd1;
          err_d   = ~done;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter4.sv
module tb_mem_arbiter4;

  localparam int TO = 16;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  // Reference model: who owns the resource, where the search starts,
  // how many BUSY cycles have passed, and the last granted index.
  int m_owner;
  int m_ptr;
  int m_age;
  int m_sel;

  exp_t expq[$];

  mem_arbiter4 #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_age   = 0;
    m_sel   = 0;
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic cycle(input logic [3:0] r, input logic d);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.err = 1'b0;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_sel = m_owner;
        m_age = 0;
      end
    end else if (d) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (m_age + 1 == TO) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      e.err   = 1'b1;
    end else begin
      m_age++;
    end
    e.busy  = (m_owner >= 0);
    e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    expq.push_back(e);
  endtask

  task automatic async_reset_mid_cycle();
    @(posedge clk);
    #2;
    req   = 4'b0000;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {grant, sel, busy, err}, 8'b0000_00_0_0);
    expq.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every edge the DUT presents a new output set; compare it
  // against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && expq.size() > 0) begin
        e = expq.pop_front();
        check("outputs", {grant, sel, busy, err}, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", {grant, sel, busy, err}, 8'b0000_00_0_0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single request to requester 2, then done; next grant should start at 3.
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);

    // Fairness with all requesters active and done every BUSY cycle.
    repeat (10) cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b0);

    // Force ptr to 3 via owner 2, then wrap and skip with req=0011.
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b1);
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b1);
    cycle(4'b0000, 1'b0);

    // Timeout on requester 1 with the owner dropping req mid-transaction.
    cycle(4'b0010, 1'b0);
    repeat (5) cycle(4'b0010, 1'b0);
    repeat (TO + 2) cycle(4'b0000, 1'b0);

    // done coincident with the last allowed cycle: no err.
    cycle(4'b1000, 1'b0);
    repeat (TO - 1) cycle(4'b1001, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);

    // Async reset in the middle of a grant, then restart from ptr=0.
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    async_reset_mid_cycle();
    cycle(4'b1000, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);

    // Random traffic; done is sparse so timeouts occur too.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] r;
      logic       d;
      r = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      d = ($urandom_range(0, 19) == 0);
      cycle(r, d);
    end

    repeat (2) @(negedge clk);
    n_checks++;
    if (expq.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending predictions required 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
